// File: rtl/mult_8x8_seq_ctrl.sv
// Sequential 8x8 approximate multiplier: one shared 4x4 unit stepped over the
// nibble-pair phases, partial products merged by XOR-shift (no carries).

module acc_4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);
    // The approximation lives in the XOR composition; the 4x4 core itself is exact.
    assign o_p = {4'b0, i_a} * {4'b0, i_b};
endmodule

module mult_8x8_seq_ctrl #(
    parameter int SKIP_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_prod,
    output logic        busy,
    output logic [15:0] op_count
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [7:0]  r_a, r_b;
    logic [3:0]  r_todo;
    logic [15:0] r_acc;
    logic [15:0] r_op_count;

    logic        w_skip;
    logic        w_alo, w_ahi, w_blo, w_bhi;
    logic [3:0]  w_need;
    logic [3:0]  w_cur;
    logic [3:0]  w_todo_nxt;
    logic [3:0]  w_sel_a, w_sel_b;
    logic [7:0]  w_p;
    logic [15:0] w_shifted;

    assign w_skip = (SKIP_ZERO != 0);
    assign w_alo  = |in_a[3:0];
    assign w_ahi  = |in_a[7:4];
    assign w_blo  = |in_b[3:0];
    assign w_bhi  = |in_b[7:4];

    // Phase bits in execution order: (0,0), (1,0), (0,1), (1,1) as (A nibble, B nibble).
    assign w_need[0] = !w_skip || (w_alo && w_blo);
    assign w_need[1] = !w_skip || (w_ahi && w_blo);
    assign w_need[2] = !w_skip || (w_alo && w_bhi);
    assign w_need[3] = !w_skip || (w_ahi && w_bhi);

    // Lowest pending phase runs this cycle.
    assign w_cur      = r_todo & (~r_todo + 4'd1);
    assign w_todo_nxt = r_todo & ~w_cur;

    assign w_sel_a = (w_cur[1] || w_cur[3]) ? r_a[7:4] : r_a[3:0];
    assign w_sel_b = (w_cur[2] || w_cur[3]) ? r_b[7:4] : r_b[3:0];

    acc_4 u_acc_4 (
        .i_a (w_sel_a),
        .i_b (w_sel_b),
        .o_p (w_p)
    );

    always_comb begin
        w_shifted = {4'b0, w_p, 4'b0};
        if (w_cur[0])
            w_shifted = {8'b0, w_p};
        else if (w_cur[3])
            w_shifted = {w_p, 8'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_todo     <= '0;
            r_acc      <= '0;
            r_op_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_acc   <= '0;
                        r_todo  <= w_need;
                        r_state <= (w_need == 4'd0) ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc  <= r_acc ^ w_shifted;
                    r_todo <= w_todo_nxt;
                    if (w_todo_nxt == 4'd0)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        if (r_op_count != 16'hFFFF)
                            r_op_count <= r_op_count + 16'd1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_prod  = out_valid ? r_acc : 16'h0000;
    assign op_count  = r_op_count;
endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Bench for mult_8x8_seq_ctrl: one instance per SKIP_ZERO value, vector table,
// corner-case sequences and randomized traffic against a closed-form model.

module tb_mult_8x8_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid [2];
    logic        in_ready [2];
    logic [7:0]  in_a [2];
    logic [7:0]  in_b [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [15:0] out_prod [2];
    logic        busy [2];
    logic [15:0] op_count [2];

    int n_checks = 0;
    int n_err    = 0;
    int exp_cnt [2];

    always #5 clk = ~clk;

    mult_8x8_seq_ctrl #(.SKIP_ZERO(0)) u_full (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_prod(out_prod[0]), .busy(busy[0]), .op_count(op_count[0])
    );

    mult_8x8_seq_ctrl #(.SKIP_ZERO(1)) u_skip (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_prod(out_prod[1]), .busy(busy[1]), .op_count(op_count[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Closed-form product from integer nibble products; skipped phases contribute 0.
    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
        int p00, p10, p01, p11;
        logic [15:0] r;
        p00 = int'(a[3:0]) * int'(b[3:0]);
        p10 = int'(a[7:4]) * int'(b[3:0]);
        p01 = int'(a[3:0]) * int'(b[7:4]);
        p11 = int'(a[7:4]) * int'(b[7:4]);
        r[3:0]   = p00[3:0];
        r[7:4]   = p00[7:4] ^ p10[3:0] ^ p01[3:0];
        r[11:8]  = p10[7:4] ^ p01[7:4] ^ p11[3:0];
        r[15:12] = p11[7:4];
        return r;
    endfunction

    function automatic int ref_lat(input int d, input logic [7:0] a, input logic [7:0] b);
        int n;
        if (d == 0) return 5;
        n = 0;
        if (a[3:0] != 0 && b[3:0] != 0) n++;
        if (a[7:4] != 0 && b[3:0] != 0) n++;
        if (a[3:0] != 0 && b[7:4] != 0) n++;
        if (a[7:4] != 0 && b[7:4] != 0) n++;
        return n + 1;
    endfunction

    // Accept one pair, count edges to out_valid, optionally hold off out_ready, handshake.
    task automatic run_txn(input int d, input logic [7:0] a, input logic [7:0] b, input int hold,
                           output logic [15:0] prod, output int lat);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready[d]), 32'd1);
        in_valid[d]  = 1'b1;
        in_a[d]      = a;
        in_b[d]      = b;
        out_ready[d] = (hold == 0);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        in_a[d]     = 8'($urandom);
        in_b[d]     = 8'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid[d] && lat < 20);
        prod = out_prod[d];
        if (!out_valid[d]) begin
            chk("timeout_out_valid", 32'd0, 32'd1);
            out_ready[d] = 1'b0;
            lat = 99;
        end else begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("hold_prod_stable", 32'(out_prod[d]), 32'(prod));
                chk("hold_in_ready", 32'(in_ready[d]), 32'd0);
            end
            out_ready[d] = 1'b1;
            @(posedge clk);
            #1;
            out_ready[d] = 1'b0;
            exp_cnt[d]++;
            chk("op_count_after", 32'(op_count[d]), 32'(exp_cnt[d]));
            chk("out_valid_drop", 32'(out_valid[d]), 32'd0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
    endtask

    typedef struct {
        int          d;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
        int          lat;
    } vec_t;

    initial begin
        vec_t vt [8];
        logic [15:0] prod, held;
        int lat;
        logic [7:0] ra, rb;

        vt[0] = '{0, 8'hB7, 8'h5C, 16'h3D24, 5};
        vt[1] = '{1, 8'h00, 8'hFF, 16'h0000, 1};
        vt[2] = '{1, 8'h30, 8'h09, 16'h01B0, 2};
        vt[3] = '{1, 8'hB7, 8'h5C, 16'h3D24, 5};
        vt[4] = '{0, 8'h00, 8'hFF, 16'h0000, 5};
        vt[5] = '{1, 8'hFF, 8'hFF, 16'hE1E1, 5};
        vt[6] = '{1, 8'h01, 8'h10, 16'h0010, 2};
        vt[7] = '{0, 8'h01, 8'h10, 16'h0010, 5};

        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; in_a[d] = '0; in_b[d] = '0; out_ready[d] = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready", 32'(in_ready[d]), 32'd1);
            chk("rst_out_valid", 32'(out_valid[d]), 32'd0);
            chk("rst_out_prod", 32'(out_prod[d]), 32'd0);
            chk("rst_busy", 32'(busy[d]), 32'd0);
            chk("rst_op_count", 32'(op_count[d]), 32'd0);
        end
        do_reset();

        for (int i = 0; i < 8; i++) begin
            run_txn(vt[i].d, vt[i].a, vt[i].b, 0, prod, lat);
            chk($sformatf("vec%0d_prod", i), 32'(prod), 32'(vt[i].prod));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].lat));
        end

        // Backpressure: result parked in DONE while inputs churn.
        @(negedge clk);
        in_valid[1] = 1'b1; in_a[1] = 8'h30; in_b[1] = 8'h09; out_ready[1] = 1'b0;
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid[1] && lat < 20);
        chk("bp_valid", 32'(out_valid[1]), 32'd1);
        held = out_prod[1];
        chk("bp_prod", 32'(held), 32'h01B0);
        for (int h = 0; h < 10; h++) begin
            in_a[1] = 8'($urandom);
            in_b[1] = 8'($urandom);
            in_valid[1] = h[0];
            @(negedge clk);
            chk("bp_prod_stable", 32'(out_prod[1]), 32'(held));
            chk("bp_in_ready", 32'(in_ready[1]), 32'd0);
            chk("bp_busy", 32'(busy[1]), 32'd1);
            chk("bp_op_count", 32'(op_count[1]), 32'(exp_cnt[1]));
        end
        in_valid[1] = 1'b1;
        out_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[1] = 1'b0;
        in_valid[1] = 1'b0;
        exp_cnt[1]++;
        @(negedge clk);
        chk("bp_in_ready_after", 32'(in_ready[1]), 32'd1);
        chk("bp_out_valid_after", 32'(out_valid[1]), 32'd0);
        chk("bp_out_prod_zero", 32'(out_prod[1]), 32'd0);
        chk("bp_op_count_after", 32'(op_count[1]), 32'(exp_cnt[1]));

        // Reset during the second CALC phase.
        @(negedge clk);
        in_valid[0] = 1'b1; in_a[0] = 8'hFF; in_b[0] = 8'hFF; out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("mid_rst_busy", 32'(busy[0]), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
        chk("mid_rst_out_prod", 32'(out_prod[0]), 32'd0);
        chk("mid_rst_op_count", 32'(op_count[0]), 32'd0);
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            chk("mid_rst_no_valid", 32'(out_valid[0]), 32'd0);
        end
        rst_n = 1'b1;
        out_ready[0] = 1'b0;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        run_txn(0, 8'hB7, 8'h5C, 0, prod, lat);
        chk("post_rst_prod", 32'(prod), 32'h3D24);
        chk("post_rst_lat", 32'(lat), 32'd5);

        // Randomized traffic with random backpressure, both variants.
        do_reset();
        for (int d = 0; d < 2; d++) begin
            for (int t = 0; t < 1000; t++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                if ($urandom_range(3) == 0) ra[3:0] = 4'h0;
                if ($urandom_range(3) == 0) ra[7:4] = 4'h0;
                if ($urandom_range(3) == 0) rb[3:0] = 4'h0;
                if ($urandom_range(3) == 0) rb[7:4] = 4'h0;
                run_txn(d, ra, rb, int'($urandom_range(2)), prod, lat);
                chk("rnd_prod", 32'(prod), 32'(ref_prod(ra, rb)));
                chk("rnd_lat", 32'(lat), 32'(ref_lat(d, ra, rb)));
            end
            chk("rnd_op_count_total", 32'(op_count[d]), 32'd1000);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/mult_8x8_seq_ctrl.md
# mult_8x8_seq_ctrl

Iterative sequencer that computes the 8x8 approximate product with a single shared `acc_4` 4x4 unit instead of four. It time-multiplexes that unit over up to four nibble-pair phases and composes the result by XOR-shift accumulation. This is the same composition rule used by the parallel 8x8 approximate multiplier. The block sits between the feature-extraction front end and the classifier MAC stage, on area-constrained builds, behind a valid/ready handshake on both sides.

## Interface
- `SKIP_ZERO`, default 1: when 1, phases whose A or B nibble is zero are skipped and contribute 0.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: block can accept operands; high only in IDLE.
- `in_a` input 8: operand A.
- `in_b` input 8: operand B.
- `out_valid` output 1: result valid; held until accepted.
- `out_ready` input 1: downstream accepts the result.
- `out_prod` output 16: approximate product.
- `busy` output 1: high in CALC or DONE.
- `op_count` output 16: completed transactions; saturates at 0xFFFF.

## Operation
- Phase (i,j), with i = A nibble and j = B nibble: `p = acc_4(A[4i+3:4i], B[4j+3:4j])`, 8-bit, combinational.
- Composition: `acc ^= {p, 4'b0 * (i+j)}`, i.e. p shifted left by 4*(i+j). This is an XOR, not an add; no carries propagate.
  - Equivalent closed form: `PROD[3:0] = p00[3:0]`.
  - `PROD[7:4] = p00[7:4] ^ p10[3:0] ^ p01[3:0]`.
  - `PROD[11:8] = p10[7:4] ^ p01[7:4] ^ p11[3:0]`.
  - `PROD[15:12] = p11[7:4]`.
- Phase order is fixed: (0,0), (1,0), (0,1), (1,1).
- Skip rule (SKIP_ZERO=1): a phase is skipped if its A nibble == 0 or its B nibble == 0. SKIP_ZERO=0 executes all four phases.
- FSM states and transitions:
  - IDLE: `in_ready = 1`. On `in_valid && in_ready`, latch A and B and clear acc. Go to CALC at the first non-skipped phase. If all phases are skipped, go to DONE with acc = 0.
  - CALC: each cycle, acc ^= the shifted product of the current phase. Advance to the next non-skipped phase. After the last executed phase, go to DONE.
  - DONE: `out_valid = 1`, `out_prod = acc`. On `out_ready`, increment op_count (saturating) and go to IDLE.
- `in_ready` is low in CALC and DONE; `in_valid` in those states is ignored.
- The latched operands are used for the whole transaction; `in_a`/`in_b` changes after acceptance have no effect.
- `out_prod` is stable while `out_valid` is high, and is 0 whenever `out_valid` is low.
- Exactly one `acc_4` instance exists in the block.

## Timing
- Reset values: state IDLE, acc 0, out_valid 0, out_prod 0, op_count 0, busy 0, in_ready 1.
- Reset mid-operation: the transaction is discarded, no `out_valid` pulse is produced, and op_count is unchanged.
- Latency: accept at edge k, n executed phases (0..4). `out_valid` rises after edge k+1+n.
  - SKIP_ZERO=0: always 5 edges.
  - SKIP_ZERO=1: 1 edge minimum (a zero operand gives n = 0).
- Throughput: with `out_ready` tied high, the next accept is possible at edge k+n+2. `in_ready` returns high the cycle after the output handshake.
- Backpressure: DONE holds indefinitely with `out_prod` unchanged.
- Simultaneous events: `in_valid` in DONE while `out_ready` is high is not accepted that cycle.
- op_count increments exactly on the `out_valid && out_ready` edge. At 0xFFFF it stays at 0xFFFF.

## Test plan
- Full sequence: SKIP_ZERO=0, A=0xB7, B=0x5C, out_ready=1.
  - `out_prod` equals the closed-form XOR composition of the `acc_4` model outputs.
  - `out_valid` rises exactly 5 edges after accept; op_count becomes 1.
- Zero skip: SKIP_ZERO=1, A=0x00, B=0xFF → `out_prod = 0x0000`, `out_valid` 1 edge after accept.
- Partial skip: SKIP_ZERO=1, A=0x30, B=0x09 → only phase (1,0) runs. Result = `acc_4(3,9)` shifted left by 4; latency 2 edges.
- Backpressure and operand stability: hold out_ready=0 for 10 cycles after `out_valid`.
  - `out_prod` is stable throughout; in_ready=0; op_count unchanged.
  - Changes on `in_a`/`in_b` and pulses on `in_valid` have no effect.
  - Raising out_ready → one handshake, in_ready=1 the next cycle.
- Reset mid-op: assert rst_n=0 during CALC phase 2.
  - All outputs return to their reset values asynchronously; no `out_valid`; op_count=0.
  - After release, a new transaction completes correctly.
- Randomized back-to-back: 1000 random operand pairs, random out_ready, both SKIP_ZERO values.
  - Every result matches the model; op_count = 1000; no transaction is lost or duplicated.
